multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Finite-state sequencer that drives a multi-cycle MIPS datapath, where instruction and data accesses share one memory and one ALU is reused across cycles. It replaces the single-cycle decoder and sits beside the datapath in the processor top level. It consumes the opcode, function field and ALU zero flag, and emits per-cycle mux selects, register/memory enables, ALU operation and the PC write enable.

## Interface
- No parameters. Encodings are fixed constants in the shared package.
- clk  in  1  system clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- op  in  6  instruction[31:26] from the instruction register
- func  in  6  instruction[5:0]
- zero  in  1  ALU result == 0, combinational from the datapath
- pc_en  out  1  PC load enable; branch resolution is folded in
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read, mem_write, ir_write, reg_write  out  1 each  enables
- reg_dst  out  2  00 = rt, 01 = rd, 10 = $31
- mem_to_reg  out  2  00 = ALUOut, 01 = MDR, 10 = PC (link)
- alu_src_a  out  1  0 = PC, 1 = reg A
- alu_src_b  out  2  00 = reg B, 01 = 4, 10 = sext(imm), 11 = sext(imm)<<2
- alu_op  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = {PC[31:28], addr26, 2'b00}, 11 = reg A
- instr_done  out  1  one-cycle pulse in the final state of each instruction
- illegal  out  1  one-cycle pulse in DECODE for an unsupported op/func

## Operation
- Supported instructions:
  - R-type (op 0x00): add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A, jr 0x08
  - lw 0x23, sw 0x2B, beq 0x04, bne 0x05, addi 0x08, slti 0x0A, j 0x02, jal 0x03
- Outputs are Moore, decoded from state only. Exceptions: pc_en in BRANCH uses zero; alu_op in R_EXEC uses func.
- Every output not listed for a state is 0.
- FETCH: mem_read, ir_write, i_or_d=0, alu_src_a=0, alu_src_b=01, add, pc_src=00, pc_en=1. Next state is DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, add (branch target into ALUOut). Next state by op:
  - lw/sw → MEM_ADDR
  - R-type → R_EXEC, or JR if func = 0x08
  - beq/bne → BRANCH
  - addi/slti → I_EXEC
  - j → JUMP
  - jal → JAL
  - otherwise assert illegal and go to FETCH
- MEM_ADDR: alu_src_a=1, alu_src_b=10, add. Next state is MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_read, i_or_d=1. Next state is MEM_WB.
- MEM_WB: reg_write, reg_dst=00, mem_to_reg=01, done.
- MEM_WR: mem_write, i_or_d=1, done.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op from func. An unknown func is caught in DECODE. Next state is R_WB.
- R_WB: reg_write, reg_dst=01, mem_to_reg=00, done.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op add (addi) or slt (slti). Next state is I_WB.
- I_WB: reg_write, reg_dst=00, mem_to_reg=00, done.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01. pc_en = zero for beq, ~zero for bne. Done.
- JUMP: pc_src=10, pc_en, done.
- JAL: pc_src=10, pc_en, reg_write, reg_dst=10, mem_to_reg=10, done. The link is PC+4, because PC was already incremented in FETCH.
- JR: pc_src=11, pc_en, done.
- Every "done" state returns to FETCH and pulses instr_done.
- op and func are sampled only in DECODE and the execute states. The IR is stable after FETCH, so no latching is needed here.

## Timing
- Cycles per instruction, counting FETCH: lw 5; sw, R-type, addi, slti 4; beq, bne, j, jal, jr 3.
- While rst = 1: state forced to FETCH and all outputs forced to 0, including pc_en and mem_read.
- The first FETCH outputs appear in the first cycle with rst = 0.
- Reset asserted in any state aborts the instruction. No reg_write or mem_write is issued in the reset cycle.
- zero is consumed combinationally in the BRANCH cycle only; it is ignored elsewhere.
- instr_done and illegal are never high in the same cycle.

## Structure
- Package mc_pkg holds:
  - the state enum (14 states)
  - opcode and func constants
  - alu_op, pc_src, reg_dst, mem_to_reg and alu_src_b encodings
- Sub-module alu_func_decode: combinational func → alu_op, plus a func_valid flag used by DECODE.
- Top module: state register, next-state logic and output decode.

## Test plan
- Reset: hold rst for 3 cycles in the middle of MEM_RD, then release. All outputs are 0 while reset is held; the next cycle is FETCH with pc_en=1, mem_read=1, ir_write=1.
- lw (op 0x23): the state sequence FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB is observed. In cycle 5, reg_write=1, mem_to_reg=01 and instr_done=1.
- beq with zero=1: pc_en=1 and pc_src=01 in cycle 3. The same instruction with zero=0 gives pc_en=0. bne gives the inverse result.
- R-type func 0x2A: alu_op=100 in cycle 3; in cycle 4, reg_dst=01 and reg_write=1. func 0x08 takes the JR path: pc_src=11 and pc_en=1 in cycle 3.
- jal (op 0x03): in cycle 3, reg_dst=10, mem_to_reg=10, reg_write=1, pc_src=10, pc_en=1.
- op 0x3F: illegal=1 in DECODE, no enables asserted, and the next cycle is FETCH.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, opcode/func
// constants, datapath select encodings and the per-cycle control bundle.
package mc_pkg;

   localparam int unsigned OP_W     = 6;
   localparam int unsigned FUNC_W   = 6;
   localparam int unsigned ALU_OP_W = 3;
   localparam int unsigned SEL_W    = 2;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEM_ADDR,
      S_MEM_RD,
      S_MEM_WB,
      S_MEM_WR,
      S_R_EXEC,
      S_R_WB,
      S_I_EXEC,
      S_I_WB,
      S_BRANCH,
      S_JUMP,
      S_JAL,
      S_JR
   } state_t;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
   localparam logic [OP_W-1:0] OP_LW    = 6'h23;
   localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
   localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
   localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
   localparam logic [OP_W-1:0] OP_J     = 6'h02;
   localparam logic [OP_W-1:0] OP_JAL   = 6'h03;

   localparam logic [FUNC_W-1:0] FN_ADD = 6'h20;
   localparam logic [FUNC_W-1:0] FN_SUB = 6'h22;
   localparam logic [FUNC_W-1:0] FN_AND = 6'h24;
   localparam logic [FUNC_W-1:0] FN_OR  = 6'h25;
   localparam logic [FUNC_W-1:0] FN_SLT = 6'h2A;
   localparam logic [FUNC_W-1:0] FN_JR  = 6'h08;

   localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;
   localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b001;
   localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b010;
   localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b011;
   localparam logic [ALU_OP_W-1:0] ALU_SLT = 3'b100;

   localparam logic [SEL_W-1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [SEL_W-1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [SEL_W-1:0] PC_SRC_JUMP   = 2'b10;
   localparam logic [SEL_W-1:0] PC_SRC_REG    = 2'b11;

   localparam logic [SEL_W-1:0] REG_DST_RT = 2'b00;
   localparam logic [SEL_W-1:0] REG_DST_RD = 2'b01;
   localparam logic [SEL_W-1:0] REG_DST_RA = 2'b10;

   localparam logic [SEL_W-1:0] M2R_ALUOUT = 2'b00;
   localparam logic [SEL_W-1:0] M2R_MDR    = 2'b01;
   localparam logic [SEL_W-1:0] M2R_PC     = 2'b10;

   localparam logic [SEL_W-1:0] SRCB_REG    = 2'b00;
   localparam logic [SEL_W-1:0] SRCB_FOUR   = 2'b01;
   localparam logic [SEL_W-1:0] SRCB_IMM    = 2'b10;
   localparam logic [SEL_W-1:0] SRCB_IMM_SH = 2'b11;

   typedef struct packed {
      logic                pc_en;
      logic                i_or_d;
      logic                mem_read;
      logic                mem_write;
      logic                ir_write;
      logic                reg_write;
      logic [SEL_W-1:0]    reg_dst;
      logic [SEL_W-1:0]    mem_to_reg;
      logic                alu_src_a;
      logic [SEL_W-1:0]    alu_src_b;
      logic [ALU_OP_W-1:0] alu_op;
      logic [SEL_W-1:0]    pc_src;
      logic                instr_done;
      logic                illegal;
   } ctrl_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction fields and zero flag in, control strobes out.
interface multicycle_controller_if;
   import mc_pkg::*;

   logic [OP_W-1:0]     op;
   logic [FUNC_W-1:0]   func;
   logic                zero;
   logic                pc_en;
   logic                i_or_d;
   logic                mem_read;
   logic                mem_write;
   logic                ir_write;
   logic                reg_write;
   logic [SEL_W-1:0]    reg_dst;
   logic [SEL_W-1:0]    mem_to_reg;
   logic                alu_src_a;
   logic [SEL_W-1:0]    alu_src_b;
   logic [ALU_OP_W-1:0] alu_op;
   logic [SEL_W-1:0]    pc_src;
   logic                instr_done;
   logic                illegal;

   modport master (
      input  op, func, zero,
      output pc_en, i_or_d, mem_read, mem_write, ir_write, reg_write,
             reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
             instr_done, illegal
   );

   modport slave (
      output op, func, zero,
      input  pc_en, i_or_d, mem_read, mem_write, ir_write, reg_write,
             reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
             instr_done, illegal
   );

endinterface

// File: rtl/alu_func_decode.sv
// R-type func field to ALU operation, with a validity flag for the supported set (jr included).
module alu_func_decode
   import mc_pkg::*;
(
   input  logic [FUNC_W-1:0]   func,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                func_valid
);

   always_comb begin
      alu_op     = ALU_ADD;
      func_valid = 1'b1;
      case (func)
         FN_ADD:  alu_op = ALU_ADD;
         FN_SUB:  alu_op = ALU_SUB;
         FN_AND:  alu_op = ALU_AND;
         FN_OR:   alu_op = ALU_OR;
         FN_SLT:  alu_op = ALU_SLT;
         FN_JR:   alu_op = ALU_ADD;
         default: func_valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS sequencer: state register, next-state logic and Moore output decode
// (zero feeds pc_en in BRANCH, func feeds alu_op in R_EXEC).
module multicycle_controller
   import mc_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   multicycle_controller_if.master bus
);

   state_t              state;
   state_t              state_nx;
   logic [ALU_OP_W-1:0] r_alu_op;
   logic                func_valid;
   logic                op_legal;
   ctrl_t               ctrl;

   alu_func_decode u_alu_func_decode (
      .func       (bus.func),
      .alu_op     (r_alu_op),
      .func_valid (func_valid)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= S_FETCH;
      else     state <= state_nx;
   end

   // Opcode legality; R-type additionally needs a supported func.
   always_comb begin
      op_legal = 1'b1;
      case (bus.op)
         OP_RTYPE: op_legal = func_valid;
         OP_LW, OP_SW, OP_BEQ, OP_BNE,
         OP_ADDI, OP_SLTI, OP_J, OP_JAL: op_legal = 1'b1;
         default:  op_legal = 1'b0;
      endcase
   end

   always_comb begin
      state_nx = S_FETCH;
      case (state)
         S_FETCH:    state_nx = S_DECODE;
         S_DECODE: begin
            case (bus.op)
               OP_LW, OP_SW:    state_nx = S_MEM_ADDR;
               OP_RTYPE: begin
                  if (!func_valid)          state_nx = S_FETCH;
                  else if (bus.func == FN_JR) state_nx = S_JR;
                  else                      state_nx = S_R_EXEC;
               end
               OP_BEQ, OP_BNE:  state_nx = S_BRANCH;
               OP_ADDI, OP_SLTI: state_nx = S_I_EXEC;
               OP_J:            state_nx = S_JUMP;
               OP_JAL:          state_nx = S_JAL;
               default:         state_nx = S_FETCH;
            endcase
         end
         S_MEM_ADDR: state_nx = (bus.op == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   state_nx = S_MEM_WB;
         S_R_EXEC:   state_nx = S_R_WB;
         S_I_EXEC:   state_nx = S_I_WB;
         default:    state_nx = S_FETCH;
      endcase
   end

   // Everything is held low while rst is high so no write escapes in the reset cycle.
   always_comb begin
      ctrl = '0;
      if (!rst) begin
         case (state)
            S_FETCH: begin
               ctrl.mem_read  = 1'b1;
               ctrl.ir_write  = 1'b1;
               ctrl.alu_src_b = SRCB_FOUR;
               ctrl.pc_src    = PC_SRC_ALU;
               ctrl.pc_en     = 1'b1;
            end
            S_DECODE: begin
               ctrl.alu_src_b = SRCB_IMM_SH;
               ctrl.illegal   = !op_legal;
            end
            S_MEM_ADDR: begin
               ctrl.alu_src_a = 1'b1;
               ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
               ctrl.mem_read = 1'b1;
               ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
               ctrl.reg_write  = 1'b1;
               ctrl.reg_dst    = REG_DST_RT;
               ctrl.mem_to_reg = M2R_MDR;
               ctrl.instr_done = 1'b1;
            end
            S_MEM_WR: begin
               ctrl.mem_write  = 1'b1;
               ctrl.i_or_d     = 1'b1;
               ctrl.instr_done = 1'b1;
            end
            S_R_EXEC: begin
               ctrl.alu_src_a = 1'b1;
               ctrl.alu_src_b = SRCB_REG;
               ctrl.alu_op    = r_alu_op;
            end
            S_R_WB: begin
               ctrl.reg_write  = 1'b1;
               ctrl.reg_dst    = REG_DST_RD;
               ctrl.mem_to_reg = M2R_ALUOUT;
               ctrl.instr_done = 1'b1;
            end
            S_I_EXEC: begin
               ctrl.alu_src_a = 1'b1;
               ctrl.alu_src_b = SRCB_IMM;
               ctrl.alu_op    = (bus.op == OP_SLTI) ? ALU_SLT : ALU_ADD;
            end
            S_I_WB: begin
               ctrl.reg_write  = 1'b1;
               ctrl.reg_dst    = REG_DST_RT;
               ctrl.mem_to_reg = M2R_ALUOUT;
               ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
               ctrl.alu_src_a  = 1'b1;
               ctrl.alu_src_b  = SRCB_REG;
               ctrl.alu_op     = ALU_SUB;
               ctrl.pc_src     = PC_SRC_ALUOUT;
               ctrl.pc_en      = (bus.op == OP_BEQ) ? bus.zero : !bus.zero;
               ctrl.instr_done = 1'b1;
            end
            S_JUMP: begin
               ctrl.pc_src     = PC_SRC_JUMP;
               ctrl.pc_en      = 1'b1;
               ctrl.instr_done = 1'b1;
            end
            S_JAL: begin
               ctrl.pc_src     = PC_SRC_JUMP;
               ctrl.pc_en      = 1'b1;
               ctrl.reg_write  = 1'b1;
               ctrl.reg_dst    = REG_DST_RA;
               ctrl.mem_to_reg = M2R_PC;
               ctrl.instr_done = 1'b1;
            end
            S_JR: begin
               ctrl.pc_src     = PC_SRC_REG;
               ctrl.pc_en      = 1'b1;
               ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
         endcase
      end
   end

   assign bus.pc_en      = ctrl.pc_en;
   assign bus.i_or_d     = ctrl.i_or_d;
   assign bus.mem_read   = ctrl.mem_read;
   assign bus.mem_write  = ctrl.mem_write;
   assign bus.ir_write   = ctrl.ir_write;
   assign bus.reg_write  = ctrl.reg_write;
   assign bus.reg_dst    = ctrl.reg_dst;
   assign bus.mem_to_reg = ctrl.mem_to_reg;
   assign bus.alu_src_a  = ctrl.alu_src_a;
   assign bus.alu_src_b  = ctrl.alu_src_b;
   assign bus.alu_op     = ctrl.alu_op;
   assign bus.pc_src     = ctrl.pc_src;
   assign bus.instr_done = ctrl.instr_done;
   assign bus.illegal    = ctrl.illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle comparison of the full control vector
// against hand-written expectations for each instruction class, reset abort and illegal decode.
module tb_multicycle_controller;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   multicycle_controller_if bus ();

   multicycle_controller dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Vector order: pc_en i_or_d mem_read mem_write ir_write reg_write reg_dst[2]
   //               mem_to_reg[2] alu_src_a alu_src_b[2] alu_op[3] pc_src[2] instr_done illegal
   localparam logic [19:0] E_ZERO     = 20'h0;
   localparam logic [19:0] E_FETCH    = {1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0,2'b01,3'b000,2'b00,1'b0,1'b0};
   localparam logic [19:0] E_DECODE   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b11,3'b000,2'b00,1'b0,1'b0};
   localparam logic [19:0] E_DEC_ILL  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b11,3'b000,2'b00,1'b0,1'b1};
   localparam logic [19:0] E_MEM_ADDR = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b10,3'b000,2'b00,1'b0,1'b0};
   localparam logic [19:0] E_MEM_RD   = {1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,3'b000,2'b00,1'b0,1'b0};
   localparam logic [19:0] E_MEM_WB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,1'b0,2'b00,3'b000,2'b00,1'b1,1'b0};
   localparam logic [19:0] E_MEM_WR   = {1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,3'b000,2'b00,1'b1,1'b0};
   localparam logic [19:0] E_R_EXEC   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b00,3'b000,2'b00,1'b0,1'b0};
   localparam logic [19:0] E_R_WB     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,2'b00,1'b0,2'b00,3'b000,2'b00,1'b1,1'b0};
   localparam logic [19:0] E_I_ADD    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b10,3'b000,2'b00,1'b0,1'b0};
   localparam logic [19:0] E_I_SLT    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b10,3'b100,2'b00,1'b0,1'b0};
   localparam logic [19:0] E_I_WB     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,1'b0,2'b00,3'b000,2'b00,1'b1,1'b0};
   localparam logic [19:0] E_BR_TAKEN = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b00,3'b001,2'b01,1'b1,1'b0};
   localparam logic [19:0] E_BR_NOT   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b00,3'b001,2'b01,1'b1,1'b0};
   localparam logic [19:0] E_JUMP     = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,3'b000,2'b10,1'b1,1'b0};
   localparam logic [19:0] E_JAL      = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b10,1'b0,2'b00,3'b000,2'b10,1'b1,1'b0};
   localparam logic [19:0] E_JR       = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,3'b000,2'b11,1'b1,1'b0};

   function automatic logic [19:0] observed();
      return {bus.pc_en, bus.i_or_d, bus.mem_read, bus.mem_write, bus.ir_write,
              bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a,
              bus.alu_src_b, bus.alu_op, bus.pc_src, bus.instr_done, bus.illegal};
   endfunction

   task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %05h expected %05h", tag, got, exp);
      end
   endtask

   // Settle, compare this cycle's outputs, then advance one clock.
   task automatic cyc(input string tag, input logic [19:0] exp);
      #1;
      check(tag, observed(), exp);
      @(posedge clk);
      #1;
   endtask

   logic [5:0] fn_tab  [5];
   logic [2:0] aop_tab [5];

   initial begin
      n_cmp    = 0;
      n_bad    = 0;
      rst      = 1'b1;
      bus.op   = 6'h00;
      bus.func = 6'h20;
      bus.zero = 1'b0;
      fn_tab   = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
      aop_tab  = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
      @(posedge clk);
      #1;
      cyc("reset_hold0", E_ZERO);
      cyc("reset_hold1", E_ZERO);

      // lw, then lw aborted by reset in MEM_RD and restarted
      bus.op = 6'h23;
      rst    = 1'b0;
      cyc("lw_fetch", E_FETCH);
      cyc("lw_decode", E_DECODE);
      cyc("lw_addr", E_MEM_ADDR);
      cyc("lw_rd", E_MEM_RD);
      cyc("lw_wb", E_MEM_WB);
      cyc("lw2_fetch", E_FETCH);
      cyc("lw2_decode", E_DECODE);
      cyc("lw2_addr", E_MEM_ADDR);
      rst = 1'b1;
      cyc("rst_in_rd0", E_ZERO);
      cyc("rst_in_rd1", E_ZERO);
      cyc("rst_in_rd2", E_ZERO);
      rst = 1'b0;
      cyc("rst_rel_fetch", E_FETCH);
      cyc("rst_rel_decode", E_DECODE);
      cyc("rst_rel_addr", E_MEM_ADDR);
      cyc("rst_rel_rd", E_MEM_RD);
      cyc("rst_rel_wb", E_MEM_WB);

      // sw
      bus.op = 6'h2B;
      cyc("sw_fetch", E_FETCH);
      cyc("sw_decode", E_DECODE);
      cyc("sw_addr", E_MEM_ADDR);
      cyc("sw_wr", E_MEM_WR);

      // beq/bne with zero driven opposite outside BRANCH to show it is ignored there
      bus.op = 6'h04; bus.zero = 1'b0;
      cyc("beq1_fetch", E_FETCH);
      cyc("beq1_decode", E_DECODE);
      bus.zero = 1'b1;
      cyc("beq_z1", E_BR_TAKEN);
      cyc("beq0_fetch", E_FETCH);
      cyc("beq0_decode", E_DECODE);
      bus.zero = 1'b0;
      cyc("beq_z0", E_BR_NOT);
      bus.op = 6'h05;
      cyc("bne1_fetch", E_FETCH);
      cyc("bne1_decode", E_DECODE);
      bus.zero = 1'b1;
      cyc("bne_z1", E_BR_NOT);
      cyc("bne0_fetch", E_FETCH);
      bus.zero = 1'b1;
      cyc("bne0_decode", E_DECODE);
      bus.zero = 1'b0;
      cyc("bne_z0", E_BR_TAKEN);

      // R-type arithmetic/logic table
      bus.op = 6'h00;
      for (int i = 0; i < 5; i++) begin
         bus.func = fn_tab[i];
         cyc("r_fetch", E_FETCH);
         cyc("r_decode", E_DECODE);
         cyc($sformatf("r_exec_fn%02h", fn_tab[i]), E_R_EXEC | (20'(aop_tab[i]) << 4));
         cyc("r_wb", E_R_WB);
      end

      // jr
      bus.func = 6'h08;
      cyc("jr_fetch", E_FETCH);
      cyc("jr_decode", E_DECODE);
      cyc("jr_exec", E_JR);

      // addi / slti
      bus.op = 6'h08;
      cyc("addi_fetch", E_FETCH);
      cyc("addi_decode", E_DECODE);
      cyc("addi_exec", E_I_ADD);
      cyc("addi_wb", E_I_WB);
      bus.op = 6'h0A;
      cyc("slti_fetch", E_FETCH);
      cyc("slti_decode", E_DECODE);
      cyc("slti_exec", E_I_SLT);
      cyc("slti_wb", E_I_WB);

      // j / jal
      bus.op = 6'h02;
      cyc("j_fetch", E_FETCH);
      cyc("j_decode", E_DECODE);
      cyc("j_exec", E_JUMP);
      bus.op = 6'h03;
      cyc("jal_fetch", E_FETCH);
      cyc("jal_decode", E_DECODE);
      cyc("jal_exec", E_JAL);

      // illegal opcode and illegal R-type func both return straight to FETCH
      bus.op = 6'h3F;
      cyc("ill_op_fetch", E_FETCH);
      cyc("ill_op_decode", E_DEC_ILL);
      bus.op = 6'h00; bus.func = 6'h21;
      cyc("ill_op_next", E_FETCH);
      cyc("ill_fn_decode", E_DEC_ILL);
      bus.op = 6'h02;
      cyc("ill_fn_next", E_FETCH);
      cyc("after_ill_decode", E_DECODE);
      cyc("after_ill_jump", E_JUMP);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
